// File: rtl/d_storage_trio.sv
// d_storage_trio: a level-sensitive D latch and two D flops (async clear, sync clear) side by side on a shared d.
// Latency: the latch passes d through with zero delay while clk=1; both flops update one rising edge after d.
// Backpressure: none. Outputs come straight from the storage elements and have no handshake.
//
// Ports:
//   clk        flop clock (rising edge) and latch enable (transparent while high)
//   rst_n      asynchronous reset, ACTIVE-HIGH despite the name; the sync lane samples it at the edge
//   d          shared data input, WIDTH bits
//   q_latch    latch output
//   q_dff_asyn flop output, asynchronous clear
//   q_dff_syn  flop output, synchronous clear
module d_storage_trio #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_latch,
   output logic [WIDTH-1:0] q_dff_asyn,
   output logic [WIDTH-1:0] q_dff_syn
);

   // Latch lane. Clear wins over the enable. With clk=0 the lane holds the
   // value it had when clk fell.
   always_latch begin
      if (rst_n)
         q_latch <= '0;
      else if (clk)
         q_latch <= d;
   end

   // Async-clear lane. Clears as soon as rst_n rises and stays clear while
   // it is held, whatever clk is doing.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n)
         q_dff_asyn <= '0;
      else
         q_dff_asyn <= d;
   end

   // Sync-clear lane. rst_n is sampled only at the rising edge, so a reset
   // pulse that falls entirely between two edges does not affect this lane.
   always_ff @(posedge clk) begin
      if (rst_n)
         q_dff_syn <= '0;
      else
         q_dff_syn <= d;
   end

endmodule

// File: tb/tb_d_storage_trio.sv
// Directed bench for d_storage_trio at WIDTH=8. Expected values are queued as
// stimulus is applied, and a monitor pops each one and compares it.
module tb_d_storage_trio;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] d;
   logic [W-1:0] q_latch;
   logic [W-1:0] q_dff_asyn;
   logic [W-1:0] q_dff_syn;

   int tests_run = 0;
   int tests_failed = 0;

   typedef struct {
      string        name;
      logic [W-1:0] l;
      logic [W-1:0] a;
      logic [W-1:0] s;
      bit           chk_s;
   } exp_t;

   exp_t sb[$];

   d_storage_trio #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d          (d),
      .q_latch    (q_latch),
      .q_dff_asyn (q_dff_asyn),
      .q_dff_syn  (q_dff_syn)
   );

   // Period 200: rising edges at 100, 300, 500, ...
   initial begin
      clk = 1'b0;
      forever #100 clk = ~clk;
   end

   // Queue an expectation. The monitor samples 1 time unit later, and this
   // task returns only after that sample has been taken.
   task automatic expect_out(input string name, input logic [W-1:0] l,
                             input logic [W-1:0] a, input logic [W-1:0] s,
                             input bit chk_s);
      exp_t e;
      e.name = name; e.l = l; e.a = a; e.s = s; e.chk_s = chk_s;
      sb.push_back(e);
      #2;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         wait (sb.size() > 0);
         #1;
         e = sb[0];
         tests_run++;
         if (q_latch !== e.l) begin
            tests_failed++;
            $display("FAIL %s q_latch: got %h expected %h", e.name, q_latch, e.l);
         end
         tests_run++;
         if (q_dff_asyn !== e.a) begin
            tests_failed++;
            $display("FAIL %s q_dff_asyn: got %h expected %h", e.name, q_dff_asyn, e.a);
         end
         if (e.chk_s) begin
            tests_run++;
            if (q_dff_syn !== e.s) begin
               tests_failed++;
               $display("FAIL %s q_dff_syn: got %h expected %h", e.name, q_dff_syn, e.s);
            end
         end
         void'(sb.pop_front());
      end
   end

   initial begin
      rst_n = 1'b1;
      d     = 8'hFF;
      // The sync lane is unknown until the first edge, so it is not checked here.
      expect_out("reset_t0", 8'h00, 8'h00, 8'h00, 1'b0);

      // Reset held across a rising edge with d all ones.
      @(posedge clk); #20;
      expect_out("reset_edge", 8'h00, 8'h00, 8'h00, 1'b1);

      // Release while clk=0. The latch keeps the value it held when clk fell.
      @(negedge clk); #20;
      rst_n = 1'b0;
      expect_out("release_clk0", 8'h00, 8'h00, 8'h00, 1'b1);

      // First capture edge.
      @(posedge clk); #20;
      expect_out("capture_ff", 8'hFF, 8'hFF, 8'hFF, 1'b1);

      // Change d while clk=1. Only the latch follows it.
      d = 8'hA5;
      expect_out("latch_transp", 8'hA5, 8'hFF, 8'hFF, 1'b1);

      // Change d while clk=0. Every output holds.
      @(negedge clk); #20;
      d = 8'h00;
      expect_out("latch_hold", 8'hA5, 8'hFF, 8'hFF, 1'b1);

      @(posedge clk); #20;
      expect_out("capture_00", 8'h00, 8'h00, 8'h00, 1'b1);

      // Bitwise independence: the lanes should follow a mixed pattern.
      d = 8'h3C;
      expect_out("latch_3c", 8'h3C, 8'h00, 8'h00, 1'b1);
      @(posedge clk); #20;
      expect_out("capture_3c", 8'h3C, 8'h3C, 8'h3C, 1'b1);

      d = 8'hFF;
      @(posedge clk); #20;
      expect_out("capture_ff2", 8'hFF, 8'hFF, 8'hFF, 1'b1);

      // 50-unit reset pulse between edges while clk=0.
      @(negedge clk); #20;
      rst_n = 1'b1;
      expect_out("pulse_assert", 8'h00, 8'h00, 8'hFF, 1'b1);
      #48;
      rst_n = 1'b0;
      expect_out("pulse_release", 8'h00, 8'h00, 8'hFF, 1'b1);

      @(posedge clk); #20;
      expect_out("recover_ff", 8'hFF, 8'hFF, 8'hFF, 1'b1);

      // Assert reset while clk=1. The sync lane holds until the next edge.
      rst_n = 1'b1;
      expect_out("assert_clk1", 8'h00, 8'h00, 8'hFF, 1'b1);
      @(posedge clk); #20;
      expect_out("sync_cleared", 8'h00, 8'h00, 8'h00, 1'b1);

      // Release while clk=1. The latch resumes at once; the flops wait for an edge.
      rst_n = 1'b0;
      expect_out("release_clk1", 8'hFF, 8'h00, 8'h00, 1'b1);
      @(negedge clk); #20;
      expect_out("release_hold", 8'hFF, 8'h00, 8'h00, 1'b1);
      @(posedge clk); #20;
      expect_out("release_edge", 8'hFF, 8'hFF, 8'hFF, 1'b1);

      // WIDTH=8 with d=A5, loaded while clk=0, then one rising edge.
      @(negedge clk); #20;
      d = 8'hA5;
      expect_out("a5_pre", 8'hFF, 8'hFF, 8'hFF, 1'b1);
      @(posedge clk); #20;
      expect_out("a5_edge", 8'hA5, 8'hA5, 8'hA5, 1'b1);

      // Let the monitor drain, with a bound on how long that may take.
      for (int i = 0; i < 100; i++) begin
         if (sb.size() != 0) #1;
      end
      if (sb.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
